m_am_lsu: RTL

M_AM_LSU -- requirements
Module: m_am_lsu

---
 rtl/m_am_lsu.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/m_am_lsu.sv
// ---------------------------------------------------------------------------
// m_am_lsu : RV32I load/store unit in front of a word-wide data memory.
//
// A CPU request is accepted in IDLE and walked through a small FSM:
//   loads         IDLE -> RD -> RESP
//   SW            IDLE -> WR -> RESP
//   SB / SH       IDLE -> RD -> WR -> RESP   (read-modify-write)
//   rejected      IDLE -> RESP               (w_err=1, no memory cycle)
//
// Optional feature macro: M_AM_LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses are rejected
//   undefined : the offending low address bits are forced to zero
//
// Ports
//   w_clk, w_rst_n        clock, asynchronous active-low reset
//   w_req, w_we           request strobe (sampled in IDLE), 1=store
//   w_funct3              RV32I width/sign code
//   w_adr, w_wd           byte address, right-aligned store data
//   w_ready               idle, can accept a request
//   w_done                one-cycle completion pulse
//   w_rdata, w_err        load data / rejection flag, valid with w_done
//   w_mem_adr/we/wd       word-aligned memory address, write enable, data
//   w_mem_rd              combinational memory read data
// ---------------------------------------------------------------------------
module m_am_lsu #(
   parameter int MEM_WORDS = 64
) (
   input  logic        w_clk,
   input  logic        w_rst_n,
   input  logic        w_req,
   input  logic        w_we,
   input  logic [2:0]  w_funct3,
   input  logic [31:0] w_adr,
   input  logic [31:0] w_wd,
   output logic        w_ready,
   output logic        w_done,
   output logic [31:0] w_rdata,
   output logic        w_err,
   output logic [31:0] w_mem_adr,
   output logic        w_mem_we,
   output logic [31:0] w_mem_wd,
   input  logic [31:0] w_mem_rd
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t      r_state;
   state_t      w_nxt;

   logic        r_we;
   logic [2:0]  r_f3;
   logic [31:0] r_adr;
   logic [31:0] r_wd;
   logic [31:0] r_buf;
   logic        r_err;

   logic        w_rej;
   logic [31:0] w_adr_al;
   logic        w_accept;
   logic [31:0] w_merge;
   logic [31:0] w_ld;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_accept = (r_state == S_IDLE) && w_req;

   // Request classification on the incoming (not yet latched) fields
   always_comb begin
      w_rej    = 1'b0;
      w_adr_al = w_adr;
      case (w_funct3)
         3'b011, 3'b110, 3'b111: w_rej = 1'b1;
         3'b100, 3'b101:         w_rej = w_we;   // no unsigned stores
         default:                ;
      endcase
      if (w_adr[31:2] >= 30'(MEM_WORDS)) w_rej = 1'b1;
`ifdef M_AM_LSU_MISALIGN_TRAP_EN
      if ((w_funct3[1:0] == 2'b01) && w_adr[0])             w_rej = 1'b1;
      if ((w_funct3[1:0] == 2'b10) && (w_adr[1:0] != 2'b00)) w_rej = 1'b1;
`else
      // Silently align: drop the low bits the access width cannot use
      if (w_funct3[1:0] == 2'b01) w_adr_al[0]   = 1'b0;
      if (w_funct3[1:0] == 2'b10) w_adr_al[1:0] = 2'b00;
`endif
   end

   // Request latch and read buffer
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_we  <= 1'b0;
         r_f3  <= 3'b000;
         r_adr <= 32'h0;
         r_wd  <= 32'h0;
         r_err <= 1'b0;
         r_buf <= 32'h0;
      end else begin
         if (w_accept) begin
            r_we  <= w_we;
            r_f3  <= w_funct3;
            r_adr <= w_adr_al;
            r_wd  <= w_wd;
            r_err <= w_rej;
         end
         if (r_state == S_RD) r_buf <= w_mem_rd;
      end
   end

   // State register
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) r_state <= S_IDLE;
      else          r_state <= w_nxt;
   end

   // Next-state logic
   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (w_rej)                                w_nxt = S_RESP;
               else if (w_we && (w_funct3[1:0] == 2'b10)) w_nxt = S_WR;
               else                                      w_nxt = S_RD;
            end
         end
         S_RD:    w_nxt = r_we ? S_WR : S_RESP;
         S_WR:    w_nxt = S_RESP;
         S_RESP:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   // Sub-word store merge into the buffered word (little-endian lanes)
   always_comb begin
      w_merge = r_wd;
      case (r_f3[1:0])
         2'b00: begin
            case (r_adr[1:0])
               2'd0:    w_merge = {r_buf[31:8],  r_wd[7:0]};
               2'd1:    w_merge = {r_buf[31:16], r_wd[7:0], r_buf[7:0]};
               2'd2:    w_merge = {r_buf[31:24], r_wd[7:0], r_buf[15:0]};
               default: w_merge = {r_wd[7:0],    r_buf[23:0]};
            endcase
         end
         2'b01:   w_merge = r_adr[1] ? {r_wd[15:0], r_buf[15:0]}
                                     : {r_buf[31:16], r_wd[15:0]};
         default: w_merge = r_wd;
      endcase
   end

   // Load lane select and extension
   always_comb begin
      case (r_adr[1:0])
         2'd0:    w_byte = r_buf[7:0];
         2'd1:    w_byte = r_buf[15:8];
         2'd2:    w_byte = r_buf[23:16];
         default: w_byte = r_buf[31:24];
      endcase
      w_half = r_adr[1] ? r_buf[31:16] : r_buf[15:0];
      case (r_f3)
         3'b000:  w_ld = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ld = {24'h0, w_byte};
         3'b001:  w_ld = {{16{w_half[15]}}, w_half};
         3'b101:  w_ld = {16'h0, w_half};
         default: w_ld = r_buf;
      endcase
   end

   // Output logic; memory bus is quiet outside RD/WR
   always_comb begin
      w_ready   = 1'b0;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_rdata   = 32'h0;
      w_mem_adr = 32'h0;
      w_mem_we  = 1'b0;
      w_mem_wd  = 32'h0;
      case (r_state)
         S_IDLE: w_ready = 1'b1;
         S_RD:   w_mem_adr = {r_adr[31:2], 2'b00};
         S_WR: begin
            w_mem_adr = {r_adr[31:2], 2'b00};
            w_mem_we  = 1'b1;
            w_mem_wd  = w_merge;
         end
         S_RESP: begin
            w_done  = 1'b1;
            w_err   = r_err;
            w_rdata = (r_err || r_we) ? 32'h0 : w_ld;
         end
         default: ;
      endcase
   end

endmodule
